// File: rtl/coeff_regfile_if.sv
// SPI-facing bus of coeff_regfile: write strobe, read port and the active coefficient bank.
interface coeff_regfile_if #(
  parameter int unsigned NUM_TAPS = 32,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned ADDR_W   = 8
);
  logic                       load;
  logic [ADDR_W-1:0]          register_address;
  logic [DATA_W-1:0]          register_value;
  logic [ADDR_W-1:0]          read_address;
  logic [DATA_W-1:0]          read_value;
  logic [NUM_TAPS*DATA_W-1:0] coeffs;
  logic                       coeff_valid;
  logic                       bank_swap;

  modport master (
    output load, register_address, register_value, read_address,
    input  read_value, coeffs, coeff_valid, bank_swap
  );

  modport slave (
    input  load, register_address, register_value, read_address,
    output read_value, coeffs, coeff_valid, bank_swap
  );
endinterface

// File: rtl/coeff_regfile.sv
// FIR coefficient register file: SCK-domain write strobe synchronised into clk, shadow bank
// written per tap, committed atomically to the active bank, plus control/status registers.
module coeff_regfile #(
  parameter int unsigned       NUM_TAPS    = 32,
  parameter int unsigned       DATA_W      = 12,
  parameter int unsigned       ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] CTRL_ADDR   = 8'h20,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 8'h21
) (
  input logic            clk,
  input logic            rst,
  coeff_regfile_if.slave bus
);
  localparam int unsigned       IdxW     = $clog2(NUM_TAPS);
  localparam logic [ADDR_W-1:0] NumTapsA = ADDR_W'(NUM_TAPS);

  typedef enum logic [1:0] {StIdle, StCapture, StApply} state_e;
  state_e r_state, w_state_next;

  logic              r_s1, r_s2, r_s3;
  logic              w_wr_evt;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_val;
  logic [DATA_W-1:0] r_shadow [NUM_TAPS];
  logic [DATA_W-1:0] r_active [NUM_TAPS];
  logic [DATA_W-1:0] r_read_value;
  logic [DATA_W-1:0] w_read_mux;
  logic              r_dirty, r_coeff_valid, r_bank_swap;
  logic [7:0]        r_wr_cnt;
  logic [3:0]        r_err_cnt;
  logic [4:0]        w_err_sum;
  logic              w_apply, w_tap_wr, w_ctrl_wr, w_commit, w_clear, w_bad_wr, w_drop;
  logic [IdxW-1:0]   w_idx;

  // s1 is the metastability stage; the rising edge is detected between s2 and s3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.load;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_wr_evt = r_s2 & ~r_s3;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_wr_evt) w_state_next = StCapture;
      StCapture: w_state_next = StApply;
      StApply:   w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  assign w_apply   = (r_state == StApply);
  assign w_tap_wr  = w_apply && (r_hold_addr < NumTapsA);
  assign w_ctrl_wr = w_apply && (r_hold_addr == CTRL_ADDR);
  assign w_commit  = w_ctrl_wr && r_hold_val[0];
  assign w_clear   = w_ctrl_wr && r_hold_val[1];
  assign w_bad_wr  = w_apply && !w_tap_wr && !w_ctrl_wr;
  assign w_drop    = w_wr_evt && (r_state != StIdle);
  assign w_idx     = r_hold_addr[IdxW-1:0];
  assign w_err_sum = {1'b0, r_err_cnt} + {4'b0, w_bad_wr} + {4'b0, w_drop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_hold_addr   <= '0;
      r_hold_val    <= '0;
      r_dirty       <= 1'b0;
      r_coeff_valid <= 1'b0;
      r_bank_swap   <= 1'b0;
      r_wr_cnt      <= '0;
      r_err_cnt     <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      r_state     <= w_state_next;
      r_bank_swap <= w_commit;
      r_err_cnt   <= (w_err_sum > 5'd15) ? 4'hf : w_err_sum[3:0];
      if (r_state == StCapture) begin
        r_hold_addr <= bus.register_address;
        r_hold_val  <= bus.register_value;
      end
      if (w_tap_wr) begin
        r_shadow[w_idx] <= r_hold_val;
        r_dirty         <= 1'b1;
        r_wr_cnt        <= r_wr_cnt + 8'd1;
      end
      // Commit samples the pre-clear shadow; a simultaneous clear then re-dirties it.
      if (w_commit) begin
        for (int k = 0; k < NUM_TAPS; k++) r_active[k] <= r_shadow[k];
        r_coeff_valid <= 1'b1;
        r_dirty       <= 1'b0;
      end
      if (w_clear) begin
        for (int k = 0; k < NUM_TAPS; k++) r_shadow[k] <= '0;
        r_dirty <= 1'b1;
      end
    end
  end

  always_comb begin
    w_read_mux = '0;
    if (bus.read_address < NumTapsA) begin
      w_read_mux = r_shadow[bus.read_address[IdxW-1:0]];
    end else if (bus.read_address == CTRL_ADDR) begin
      w_read_mux = {{(DATA_W-2){1'b0}}, r_dirty, r_coeff_valid};
    end else if (bus.read_address == STATUS_ADDR) begin
      w_read_mux = DATA_W'({r_err_cnt, r_wr_cnt});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_read_value <= '0;
    else     r_read_value <= w_read_mux;
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_coeffs
    assign bus.coeffs[k*DATA_W +: DATA_W] = r_active[k];
  end

  assign bus.read_value  = r_read_value;
  assign bus.coeff_valid = r_coeff_valid;
  assign bus.bank_swap   = r_bank_swap;
endmodule

// File: tb/tb_coeff_regfile.sv
// Directed bench for coeff_regfile: shadow writes, atomic commit, clear, counters and reset abort.
module tb_coeff_regfile;
  localparam int unsigned NT = 32;
  localparam int unsigned DW = 12;
  localparam int unsigned AW = 8;
  localparam int unsigned VW = NT * DW;
  localparam logic [AW-1:0] CTRL   = 8'h20;
  localparam logic [AW-1:0] STATUS = 8'h21;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  int swap_cnt = 0;
  int change_cnt = 0;
  int glitch_cnt = 0;
  int swap_base, chg_base;
  logic [VW-1:0] prev_coeffs = '0;
  logic [VW-1:0] exp_vec;

  coeff_regfile_if #(.NUM_TAPS(NT), .DATA_W(DW), .ADDR_W(AW)) bus ();

  coeff_regfile #(
    .NUM_TAPS(NT), .DATA_W(DW), .ADDR_W(AW), .CTRL_ADDR(CTRL), .STATUS_ADDR(STATUS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Counts swap pulses and any active-bank change not accompanied by bank_swap.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.bank_swap) swap_cnt++;
      if (bus.coeffs !== prev_coeffs) begin
        change_cnt++;
        if (!bus.bank_swap) glitch_cnt++;
      end
    end
    prev_coeffs = bus.coeffs;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk12(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
    bus.register_address = a;
    bus.register_value   = v;
    bus.load             = 1'b1;
    tick(4);
    bus.load = 1'b0;
    tick(8);
  endtask

  task automatic rd(input logic [AW-1:0] a, input string tag, input logic [DW-1:0] exp);
    bus.read_address = a;
    tick(1);
    chk12(tag, bus.read_value, exp);
  endtask

  initial begin
    bus.load             = 1'b0;
    bus.register_address = '0;
    bus.register_value   = '0;
    bus.read_address     = '0;
    rst = 1'b1;
    tick(3);
    chk12("rst_read_value", bus.read_value, 12'h000);
    chk_vec("rst_coeffs", bus.coeffs, '0);
    chk_int("rst_valid", int'(bus.coeff_valid), 0);
    chk_int("rst_swap", int'(bus.bank_swap), 0);
    rst = 1'b0;
    tick(2);
    rd(CTRL, "rst_ctrl", 12'h000);
    rd(STATUS, "rst_status", 12'h000);

    // 1: single tap write with exact latency through the synchroniser and FSM.
    bus.read_address     = 8'd5;
    bus.register_address = 8'd5;
    bus.register_value   = 12'habc;
    bus.load             = 1'b1;
    tick(4);
    bus.load = 1'b0;
    tick(1);
    chk12("t1_read_old", bus.read_value, 12'h000);
    tick(1);
    chk12("t1_read_new", bus.read_value, 12'habc);
    tick(6);
    chk_vec("t1_coeffs_idle", bus.coeffs, '0);
    chk_int("t1_valid", int'(bus.coeff_valid), 0);
    rd(CTRL, "t1_ctrl", 12'h002);

    // 2: fill all taps then commit.
    swap_base = swap_cnt;
    chg_base  = change_cnt;
    for (int k = 0; k < NT; k++) wr(AW'(k), DW'(k + 1));
    chk_vec("t2_precommit", bus.coeffs, '0);
    wr(CTRL, 12'h001);
    for (int k = 0; k < NT; k++) exp_vec[k*DW +: DW] = DW'(k + 1);
    chk_vec("t2_coeffs", bus.coeffs, exp_vec);
    chk_int("t2_swaps", swap_cnt - swap_base, 1);
    chk_int("t2_changes", change_cnt - chg_base, 1);
    chk_int("t2_valid", int'(bus.coeff_valid), 1);
    rd(CTRL, "t2_ctrl", 12'h001);
    rd(8'd5, "t2_tap5", 12'h006);
    rd(8'd31, "t2_tap31", 12'h020);
    rd(8'h30, "t2_unmapped", 12'h000);

    // 3: bad addresses count errors, saturate at 15.
    rd(STATUS, "t3_status0", 12'h021);
    wr(8'h40, 12'h555);
    wr(STATUS, 12'h777);
    rd(STATUS, "t3_status2", 12'h221);
    rd(CTRL, "t3_ctrl", 12'h001);
    rd(8'd0, "t3_tap0", 12'h001);
    chk_vec("t3_coeffs", bus.coeffs, exp_vec);
    for (int i = 0; i < 20; i++) wr(AW'(8'h40 + i), 12'h0f0);
    rd(STATUS, "t3_err_sat", 12'hf21);

    // 4: write counter wraps.
    for (int i = 0; i < 223; i++) wr(AW'(i % NT), DW'((i % NT) + 1));
    rd(STATUS, "t4_wrap0", 12'hf00);
    for (int i = 0; i < 256; i++) wr(AW'(i % NT), DW'((i % NT) + 1));
    rd(STATUS, "t4_wrap256", 12'hf00);
    for (int i = 0; i < 3; i++) wr(AW'(i), DW'(i + 1));
    rd(STATUS, "t4_wr3", 12'hf03);
    rd(CTRL, "t4_ctrl", 12'h003);

    // 5: commit and clear together.
    wr(8'd3, 12'h333);
    exp_vec[3*DW +: DW] = 12'h333;
    swap_base = swap_cnt;
    wr(CTRL, 12'h003);
    chk_vec("t5_coeffs", bus.coeffs, exp_vec);
    chk_int("t5_swaps", swap_cnt - swap_base, 1);
    rd(8'd3, "t5_tap3_clr", 12'h000);
    rd(8'd31, "t5_tap31_clr", 12'h000);
    rd(CTRL, "t5_ctrl", 12'h003);
    wr(CTRL, 12'h004);
    chk_int("t5_noop_swaps", swap_cnt - swap_base, 1);
    chk_vec("t5_noop_coeffs", bus.coeffs, exp_vec);
    rd(STATUS, "t5_status", 12'hf04);

    // 6: reset while a write is between capture and apply.
    wr(8'd7, 12'h007);
    rd(8'd7, "t6_tap7", 12'h007);
    bus.register_address = 8'd7;
    bus.register_value   = 12'hfff;
    bus.load             = 1'b1;
    tick(3);
    rst      = 1'b1;
    bus.load = 1'b0;
    tick(2);
    chk12("t6_rst_read", bus.read_value, 12'h000);
    chk_vec("t6_rst_coeffs", bus.coeffs, '0);
    chk_int("t6_rst_valid", int'(bus.coeff_valid), 0);
    chk_int("t6_rst_swap", int'(bus.bank_swap), 0);
    rst = 1'b0;
    tick(6);
    rd(8'd7, "t6_no_partial", 12'h000);
    rd(STATUS, "t6_status", 12'h000);
    rd(CTRL, "t6_ctrl", 12'h000);
    wr(8'd9, 12'h099);
    rd(8'd9, "t6_tap9", 12'h099);
    rd(STATUS, "t6_status1", 12'h001);
    rd(CTRL, "t6_ctrl1", 12'h002);

    chk_int("glitches", glitch_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
